// File: rtl/lock_timer_pkg.sv
// Shared types and constants for the lock timer bank.
// The channel state enum is also exported for debug observation.
package lock_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } t_tmr_state;

  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/lock_timer_ch.sv
// One timer channel: state machine plus tick counter, with one-shot or auto-reload expiry.
// Control priority each cycle is clear > start > pause > tick.
module lock_timer_ch
  import lock_timer_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int DEF_LIMIT = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_tick,
  input  logic             i_start,
  input  logic             i_clear,
  input  logic             i_pause,
  input  logic             i_autoreload,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expired,
  output logic             o_expired_pulse,
  output logic             o_pulse_nxt,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_count,
  output t_tmr_state       o_state
);

  t_tmr_state       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_limit, w_limit_nxt;
  logic             r_mode, w_mode_nxt;
  logic             r_expired, w_expired_nxt;
  logic             r_pulse, w_pulse_nxt;
  logic             r_busy, w_busy_nxt;
  logic [CNT_W-1:0] w_inc;

  assign w_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_limit   <= '0;
      r_mode    <= 1'b0;
      r_expired <= 1'b0;
      r_pulse   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_limit   <= w_limit_nxt;
      r_mode    <= w_mode_nxt;
      r_expired <= w_expired_nxt;
      r_pulse   <= w_pulse_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_limit_nxt   = r_limit;
    w_mode_nxt    = r_mode;
    w_expired_nxt = r_expired;
    w_pulse_nxt   = 1'b0;
    if (i_clear) begin
      w_state_nxt   = IDLE;
      w_cnt_nxt     = '0;
      w_expired_nxt = 1'b0;
    end else if (i_start) begin
      w_state_nxt   = RUN;
      w_cnt_nxt     = '0;
      w_expired_nxt = 1'b0;
      w_limit_nxt   = (i_load_val == '0) ? CNT_W'(DEF_LIMIT) : i_load_val;
      w_mode_nxt    = i_autoreload;
    end else begin
      case (r_state)
        RUN: begin
          if (i_pause) begin
            w_state_nxt = PAUSED;
          end else if (i_tick) begin
            // The limit is never 0 while running, so w_inc cannot overshoot it.
            if (w_inc != r_limit) begin
              w_cnt_nxt = w_inc;
            end else if (r_mode) begin
              w_cnt_nxt   = '0;
              w_pulse_nxt = 1'b1;
            end else begin
              w_state_nxt   = EXPIRED;
              w_cnt_nxt     = r_limit;
              w_expired_nxt = 1'b1;
              w_pulse_nxt   = 1'b1;
            end
          end
        end
        PAUSED: begin
          if (!i_pause) w_state_nxt = RUN;
        end
        default: ;
      endcase
    end
    w_busy_nxt = (w_state_nxt == RUN) || (w_state_nxt == PAUSED);
  end

  assign o_expired       = r_expired;
  assign o_expired_pulse = r_pulse;
  assign o_pulse_nxt     = w_pulse_nxt;
  assign o_busy          = r_busy;
  assign o_count         = r_cnt;
  assign o_state         = r_state;

endmodule

// File: rtl/lock_timer_bank.sv
// Bank of independent programmable timers for the lock controller.
// any_expired is registered from the channels' next-pulse terms so it lines up with expired_pulse.
module lock_timer_bank
  import lock_timer_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int DEF_LIMIT = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       clear,
  input  logic [NUM_CH-1:0]       pause,
  input  logic [NUM_CH-1:0]       autoreload,
  input  logic [NUM_CH*CNT_W-1:0] load_val,
  output logic [NUM_CH-1:0]       expired,
  output logic [NUM_CH-1:0]       expired_pulse,
  output logic [NUM_CH-1:0]       busy,
  output logic                    any_expired,
  output logic [NUM_CH*CNT_W-1:0] count_out,
  output logic [2*NUM_CH-1:0]     dbg_state
);

  logic [NUM_CH-1:0] w_pulse_nxt;
  t_tmr_state        w_state [NUM_CH];
  logic              r_any_expired;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    lock_timer_ch #(
      .CNT_W     (CNT_W),
      .DEF_LIMIT (DEF_LIMIT)
    ) u_ch (
      .clk             (clk),
      .reset           (reset),
      .i_tick          (tick),
      .i_start         (start[i]),
      .i_clear         (clear[i]),
      .i_pause         (pause[i]),
      .i_autoreload    (autoreload[i]),
      .i_load_val      (load_val[i*CNT_W +: CNT_W]),
      .o_expired       (expired[i]),
      .o_expired_pulse (expired_pulse[i]),
      .o_pulse_nxt     (w_pulse_nxt[i]),
      .o_busy          (busy[i]),
      .o_count         (count_out[i*CNT_W +: CNT_W]),
      .o_state         (w_state[i])
    );
    assign dbg_state[2*i +: 2] = w_state[i];
  end

  always_ff @(posedge clk) begin
    if (reset) r_any_expired <= 1'b0;
    else       r_any_expired <= |w_pulse_nxt;
  end

  assign any_expired = r_any_expired;

endmodule

// File: tb/tb_lock_timer_bank.sv
// Directed bench for lock_timer_bank: per-cycle comparison against a tick-tally model,
// plus literal checkpoints for the scenarios of interest.
module tb_lock_timer_bank;

  localparam int NCH = 4;
  localparam int W   = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           tick = 1'b0;
  logic [NCH-1:0] start = '0, clear = '0, pause = '0, autoreload = '0;
  logic [NCH*W-1:0] load_val = '0;
  logic [NCH-1:0] expired, expired_pulse, busy;
  logic           any_expired;
  logic [NCH*W-1:0] count_out;
  logic [2*NCH-1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cycle = 0;
  int pcnt1 = 0;

  lock_timer_bank dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .clear(clear),
    .pause(pause), .autoreload(autoreload), .load_val(load_val),
    .expired(expired), .expired_pulse(expired_pulse), .busy(busy),
    .any_expired(any_expired), .count_out(count_out), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Model: each channel is described by how many ticks it has counted since start.
  bit m_arm [NCH];
  bit m_pz  [NCH];
  bit m_per [NCH];
  int m_tk  [NCH];
  int m_lim [NCH];
  bit m_pulse [NCH];

  function automatic bit m_done(int c);
    return m_arm[c] && !m_per[c] && (m_tk[c] >= m_lim[c]);
  endfunction

  function automatic int m_count(int c);
    if (!m_arm[c]) return 0;
    if (m_per[c]) return m_tk[c] % m_lim[c];
    return m_tk[c];
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      m_pulse[c] = 1'b0;
      if (reset) begin
        m_arm[c] = 0; m_pz[c] = 0; m_per[c] = 0; m_tk[c] = 0; m_lim[c] = 0;
      end else if (clear[c]) begin
        m_arm[c] = 0; m_pz[c] = 0; m_tk[c] = 0;
      end else if (start[c]) begin
        m_arm[c] = 1; m_pz[c] = 0; m_tk[c] = 0;
        m_lim[c] = (load_val[c*W +: W] == 0) ? 7 : int'(load_val[c*W +: W]);
        m_per[c] = autoreload[c];
      end else if (m_arm[c] && !m_done(c)) begin
        if (m_pz[c]) begin
          if (!pause[c]) m_pz[c] = 0;
        end else if (pause[c]) begin
          m_pz[c] = 1;
        end else if (tick) begin
          m_tk[c]++;
          if (m_tk[c] % m_lim[c] == 0) m_pulse[c] = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare, sampled well after the active edge.
  always @(posedge clk) begin
    bit any;
    #2;
    cycle++;
    any = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      any |= m_pulse[c];
      n_checks++;
      if (count_out[c*W +: W] !== W'(m_count(c)) || expired[c] !== m_done(c) ||
          expired_pulse[c] !== m_pulse[c] || busy[c] !== (m_arm[c] && !m_done(c))) begin
        n_errors++;
        $display("FAIL model ch%0d cycle %0d: got cnt=%0d exp=%b pls=%b busy=%b, want cnt=%0d exp=%b pls=%b busy=%b",
                 c, cycle, count_out[c*W +: W], expired[c], expired_pulse[c], busy[c],
                 m_count(c), m_done(c), m_pulse[c], m_arm[c] && !m_done(c));
      end
    end
    n_checks++;
    if (any_expired !== any) begin
      n_errors++;
      $display("FAIL model any_expired cycle %0d: got %b want %b", cycle, any_expired, any);
    end
    if (expired_pulse[1] === 1'b1) pcnt1++;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_tick(int n);
    repeat (n) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  task automatic do_start(int ch, logic [W-1:0] lv, bit ar, bit with_tick = 0, bit with_clear = 0);
    start[ch] = 1'b1;
    clear[ch] = with_clear;
    load_val[ch*W +: W] = lv;
    autoreload[ch] = ar;
    tick = with_tick;
    @(negedge clk);
    start = '0; clear = '0; tick = 1'b0;
  endtask

  initial begin
    idle(3);
    reset = 1'b0;
    check("reset count_out", count_out, 0);
    check("reset flags", {expired, expired_pulse, busy, any_expired}, 0);

    // Ticks without any start: nothing moves.
    repeat (5) begin do_tick(1); idle(3); end
    check("idle count_out", count_out, 0);
    check("idle busy", busy, 0);

    // Ch0 one-shot, limit 5.
    do_start(0, 8'd5, 1'b0);
    do_tick(4);
    check("ch0 before expiry pulse", expired_pulse[0], 0);
    do_tick(1);
    check("ch0 pulse", expired_pulse[0], 1);
    check("ch0 any_expired", any_expired, 1);
    check("ch0 count at expiry", count_out[7:0], 5);
    do_tick(3);
    check("ch0 pulse gone", expired_pulse[0], 0);
    check("ch0 expired held", expired[0], 1);
    check("ch0 count held", count_out[7:0], 5);

    // Ch1 auto-reload, limit 3, ten ticks.
    do_start(1, 8'd3, 1'b1);
    pcnt1 = 0;
    do_tick(10);
    check("ch1 pulse count", pcnt1, 3);
    check("ch1 expired never", expired[1], 0);
    check("ch1 count end", count_out[15:8], 1);

    // Ch2 default limit.
    do_start(2, 8'd0, 1'b0);
    do_tick(6);
    check("ch2 not yet", expired[2], 0);
    do_tick(1);
    check("ch2 default pulse", expired_pulse[2], 1);
    check("ch2 default count", count_out[23:16], 7);

    // Ch2 pause and resume.
    do_start(2, 8'd4, 1'b0);
    do_tick(2);
    pause[2] = 1'b1;
    do_tick(4);
    check("ch2 paused count", count_out[23:16], 2);
    check("ch2 paused busy", busy[2], 1);
    pause[2] = 1'b0;
    idle(1);
    do_tick(1);
    check("ch2 resumed count", count_out[23:16], 3);
    do_tick(1);
    check("ch2 pause expiry", expired_pulse[2], 1);

    // Ch3 start+tick, retrigger, clear+start, reset mid-count.
    do_start(3, 8'd6, 1'b0, 1'b1);
    check("ch3 start with tick", count_out[31:24], 0);
    do_tick(4);
    check("ch3 count 4", count_out[31:24], 4);
    do_start(3, 8'd6, 1'b0);
    check("ch3 retrigger count", count_out[31:24], 0);
    do_tick(5);
    check("ch3 no early expiry", expired[3], 0);
    do_tick(1);
    check("ch3 retrigger expiry", expired_pulse[3], 1);
    do_start(3, 8'd6, 1'b0, 1'b0, 1'b1);
    check("ch3 clear+start busy", busy[3], 0);
    check("ch3 clear+start flags", {expired[3], expired_pulse[3]}, 0);

    // Mixed traffic on all channels, then reset mid-count.
    load_val = {8'd2, 8'd9, 8'd3, 8'd4};
    autoreload = 4'b0101;
    start = 4'hF;
    @(negedge clk);
    start = '0;
    for (int i = 0; i < 40; i++) begin
      tick = ($urandom_range(0, 3) != 0);
      pause = 4'($urandom_range(0, 15)) & 4'b1010;
      @(negedge clk);
    end
    tick = 1'b0; pause = '0;
    do_start(3, 8'd6, 1'b0);
    do_tick(3);
    check("ch3 before reset", count_out[31:24], 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset mid-count count", count_out, 0);
    check("reset mid-count busy", busy, 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
